inv_sub_byte: RTL and testbench

INV_SUB_BYTE -- requirements
Module: inv_sub_byte

---
 rtl/inv_sub_byte.sv | 186 ++++++++++++++++++
 tb/tb_inv_sub_byte.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/inv_sub_byte.sv
// inv_sub_byte: AES InvSubBytes over a 128-bit state, LANES inverse S-boxes time-shared over 16 bytes.
// Latency: result valid 16/LANES cycles after the acceptance edge; a new block may be taken on the consume edge.
// Backpressure: result held in DONE until ready_in; ready_out follows ready_in in DONE, low while processing.
//
// Ports:
//   clk, rst                         rising-edge clock, asynchronous active-high reset
//   inv_sub_byte_valid_in/_ready_out input block handshake (ready_out low during reset)
//   inv_sub_byte_data_in             input state, byte i = bits [8i+7:8i]
//   inv_sub_byte_valid_out/_ready_in result handshake
//   inv_sub_byte_data_out            substituted state, same byte mapping
//   inv_sub_byte_busy                high while bytes are being substituted
module inv_sub_byte #(
  parameter int DATA_WIDTH     = 128,
  parameter int LANES          = 4,
  parameter int SELECT_SUBBYTE = 0,
  parameter int ROM_WIDTH      = 20
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inv_sub_byte_valid_in,
  output logic                  inv_sub_byte_ready_out,
  input  logic [DATA_WIDTH-1:0] inv_sub_byte_data_in,
  output logic                  inv_sub_byte_valid_out,
  input  logic                  inv_sub_byte_ready_in,
  output logic [DATA_WIDTH-1:0] inv_sub_byte_data_out,
  output logic                  inv_sub_byte_busy
);

  localparam int NGRP = 16 / LANES;
  localparam int GW   = (NGRP > 1) ? $clog2(NGRP) : 1;
  localparam logic [GW-1:0] GRP_LAST = GW'(NGRP - 1);

  // Lookup-table packing: as many whole bytes per ROM word as fit.
  localparam int EPW    = (ROM_WIDTH >= 8) ? ROM_WIDTH / 8 : 1;
  localparam int NWORDS = (256 + EPW - 1) / EPW;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PROC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  if (DATA_WIDTH != 128) begin : g_bad_width
    $error("inv_sub_byte: DATA_WIDTH must be 128");
  end
  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("inv_sub_byte: LANES must be 1, 2, 4, 8 or 16");
  end
  if (SELECT_SUBBYTE != 0 && SELECT_SUBBYTE != 1) begin : g_bad_sel
    $error("inv_sub_byte: SELECT_SUBBYTE must be 0 or 1");
  end
  if (ROM_WIDTH < 8) begin : g_bad_rom
    $error("inv_sub_byte: ROM_WIDTH must hold at least one byte");
  end

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Itoh-Tsujii inversion: n = x^17 lies in the GF(2^4) subfield, where its
  // inverse is n^14; then x^-1 = x^16 * n^-1. Maps 0 to 0 naturally.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] x16;
    logic [7:0] n;
    logic [7:0] n2;
    logic [7:0] n4;
    logic [7:0] n8;
    x16 = gf_mul(x, x);
    x16 = gf_mul(x16, x16);
    x16 = gf_mul(x16, x16);
    x16 = gf_mul(x16, x16);
    n   = gf_mul(x16, x);
    n2  = gf_mul(n, n);
    n4  = gf_mul(n2, n2);
    n8  = gf_mul(n4, n4);
    return gf_mul(x16, gf_mul(gf_mul(n2, n4), n8));
  endfunction

  // Inverse affine: rotl1 ^ rotl3 ^ rotl6 ^ 0x05, then field inverse.
  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    logic [7:0] t;
    t = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
    return gf_inv(t);
  endfunction

  function automatic logic [NWORDS*ROM_WIDTH-1:0] build_rom();
    logic [NWORDS*ROM_WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < 256; i++) begin
      r[(i / EPW) * ROM_WIDTH + (i % EPW) * 8 +: 8] = inv_sbox(8'(i));
    end
    return r;
  endfunction

  localparam logic [NWORDS*ROM_WIDTH-1:0] ROM = build_rom();

  logic [1:0]            state_q, state_d;
  logic [GW-1:0]         grp_q, grp_d;
  logic [DATA_WIDTH-1:0] work_q, work_d;
  logic                  rdy_en_q;

  logic [3:0] lane_idx [LANES];
  logic [7:0] lane_in  [LANES];
  logic [7:0] lane_out [LANES];

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      lane_idx[l] = 4'(int'(grp_q) * LANES + l);
      lane_in[l]  = work_q[{lane_idx[l], 3'b000} +: 8];
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    if (SELECT_SUBBYTE == 1) begin : g_rom
      logic [ROM_WIDTH-1:0] rom_word;
      assign rom_word    = ROM[(int'(lane_in[l]) / EPW) * ROM_WIDTH +: ROM_WIDTH];
      assign lane_out[l] = rom_word[(int'(lane_in[l]) % EPW) * 8 +: 8];
    end else begin : g_logic
      assign lane_out[l] = inv_sbox(lane_in[l]);
    end
  end

  always_comb begin
    state_d = state_q;
    grp_d   = grp_q;
    work_d  = work_q;
    case (state_q)
      ST_IDLE: begin
        if (inv_sub_byte_valid_in && rdy_en_q) begin
          work_d  = inv_sub_byte_data_in;
          grp_d   = '0;
          state_d = ST_PROC;
        end
      end
      ST_PROC: begin
        for (int l = 0; l < LANES; l++) begin
          work_d[{lane_idx[l], 3'b000} +: 8] = lane_out[l];
        end
        // Counter holds on the last group; it is cleared on the next capture.
        if (grp_q == GRP_LAST) state_d = ST_DONE;
        else                   grp_d   = grp_q + 1'b1;
      end
      ST_DONE: begin
        if (inv_sub_byte_ready_in) begin
          if (inv_sub_byte_valid_in) begin
            work_d  = inv_sub_byte_data_in;
            grp_d   = '0;
            state_d = ST_PROC;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      grp_q    <= '0;
      work_q   <= '0;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      grp_q    <= grp_d;
      work_q   <= work_d;
      rdy_en_q <= 1'b1;
    end
  end

  // rdy_en_q keeps ready_out low until the first edge after reset releases.
  assign inv_sub_byte_ready_out = ((state_q == ST_IDLE) && rdy_en_q) ||
                                  ((state_q == ST_DONE) && inv_sub_byte_ready_in);
  assign inv_sub_byte_valid_out = (state_q == ST_DONE);
  assign inv_sub_byte_busy      = (state_q == ST_PROC);
  assign inv_sub_byte_data_out  = work_q;

endmodule

// File: tb/tb_inv_sub_byte.sv
// tb_inv_sub_byte: scoreboard bench for inv_sub_byte plus a lane/variant sweep.
// Latency: expects results 16/LANES cycles after acceptance.
// Backpressure: holds ready_in low in DONE and checks the result stays put.
module tb_inv_sub_byte;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         vin = 1'b0;
  logic [127:0] din = '0;
  logic         rdy_in = 1'b1;
  logic         rdy_o, vld_o, busy_o;
  logic [127:0] dout;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  typedef struct {
    logic [127:0] d;
    int           acc;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  inv_sub_byte dut (
    .clk                    (clk),
    .rst                    (rst),
    .inv_sub_byte_valid_in  (vin),
    .inv_sub_byte_ready_out (rdy_o),
    .inv_sub_byte_data_in   (din),
    .inv_sub_byte_valid_out (vld_o),
    .inv_sub_byte_ready_in  (rdy_in),
    .inv_sub_byte_data_out  (dout),
    .inv_sub_byte_busy      (busy_o)
  );

  // Sweep instances: one block each, ready_in tied high.
  localparam int SW_L [4] = '{1, 2, 16, 4};
  localparam int SW_S [4] = '{1, 0, 1, 1};
  logic         sw_vin = 1'b0;
  logic [3:0]   sw_rdy, sw_vo, sw_busy;
  logic [127:0] sw_do [4];

  for (genvar k = 0; k < 4; k++) begin : g_sw
    inv_sub_byte #(.LANES(SW_L[k]), .SELECT_SUBBYTE(SW_S[k])) u (
      .clk                    (clk),
      .rst                    (rst),
      .inv_sub_byte_valid_in  (sw_vin),
      .inv_sub_byte_ready_out (sw_rdy[k]),
      .inv_sub_byte_data_in   (128'h76abd7fe2b670130c56f6bf27b777c63),
      .inv_sub_byte_valid_out (sw_vo[k]),
      .inv_sub_byte_ready_in  (1'b1),
      .inv_sub_byte_data_out  (sw_do[k]),
      .inv_sub_byte_busy      (sw_busy[k])
    );
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Present a block at a negedge and hold it until the DUT takes it.
  task automatic send(input logic [127:0] d, input logic [127:0] e, output int waits);
    exp_t x;
    @(negedge clk);
    vin = 1'b1;
    din = d;
    waits = 0;
    #1;
    while (!rdy_o && waits < 100) begin
      @(negedge clk);
      #1;
      waits++;
    end
    if (!rdy_o) begin
      chk("accept_timeout", 128'(rdy_o), 128'd1);
    end else begin
      x.d   = e;
      x.acc = cyc + 1;
      exp_q.push_back(x);
    end
    @(posedge clk);
    #1;
    vin = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", 128'(exp_q.size()), 128'd0);
  endtask

  // Monitor: samples after stimulus settles, compares against the queue head.
  logic prev_vld = 1'b0;
  always @(negedge clk) begin
    #2;
    if (rst) begin
      prev_vld = 1'b0;
    end else begin
      if (busy_o) chk("proc_ready_out", 128'(rdy_o), 128'd0);
      if (vld_o) begin
        if (exp_q.size() == 0) begin
          chk("spurious_valid", 128'(vld_o), 128'd0);
        end else begin
          if (!prev_vld) chk("latency", 128'(cyc - exp_q[0].acc), 128'd4);
          chk("data_out", dout, exp_q[0].d);
          if (!rdy_in) chk("bp_ready_out", 128'(rdy_o), 128'd0);
          else void'(exp_q.pop_front());
        end
      end
      prev_vld = vld_o;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    logic [127:0] held;
    int lat [4];
    logic [127:0] got [4];

    // Reset state
    #3;
    chk("rst_valid_out", 128'(vld_o), 128'd0);
    chk("rst_busy", 128'(busy_o), 128'd0);
    chk("rst_ready_out", 128'(rdy_o), 128'd0);
    chk("rst_data_out", dout, 128'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("ready_before_edge", 128'(rdy_o), 128'd0);
    @(posedge clk);
    #1;
    chk("ready_after_edge", 128'(rdy_o), 128'd1);

    // Directed vectors, ready_in high
    send({16{8'h63}}, 128'd0, w);
    send(128'h76abd7fe2b670130c56f6bf27b777c63, 128'h0f0e0d0c0b0a09080706050403020100, w);
    drain();
    send(128'h637c777bf26b6fc53001672bfed7ab76, 128'h000102030405060708090a0b0c0d0e0f, w);
    send({4{32'h7d160063}}, {4{32'h13ff5200}}, w);
    drain();

    // Backpressure then back-to-back acceptance on the consume edge
    rdy_in = 1'b0;
    send(128'd0, {16{8'h52}}, w);
    w = 0;
    while (!vld_o && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("bp_reached_done", 128'(vld_o), 128'd1);
    held = dout;
    vin = 1'b1;
    din = {16{8'h16}};
    repeat (10) begin
      @(negedge clk);
      #3;
      chk("bp_valid_hold", 128'(vld_o), 128'd1);
      chk("bp_data_hold", dout, held);
    end
    @(negedge clk);
    rdy_in = 1'b1;
    #1;
    chk("b2b_ready_out", 128'(rdy_o), 128'd1);
    begin
      exp_t x;
      x.d   = {16{8'hff}};
      x.acc = cyc + 1;
      exp_q.push_back(x);
    end
    @(posedge clk);
    #1;
    vin = 1'b0;
    @(negedge clk);
    #3;
    chk("b2b_one_cycle", 128'(vld_o), 128'd0);
    chk("b2b_busy", 128'(busy_o), 128'd1);
    drain();

    // Reset mid-processing: g == 2
    send({16{8'h7d}}, {16{8'h13}}, w);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("abort_valid_out", 128'(vld_o), 128'd0);
    chk("abort_busy", 128'(busy_o), 128'd0);
    chk("abort_ready_out", 128'(rdy_o), 128'd0);
    chk("abort_data_out", dout, 128'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    send({16{8'h7d}}, {16{8'h13}}, w);
    drain();

    // Lane / variant sweep
    @(negedge clk);
    sw_vin = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("sweep_ready", 128'(sw_rdy[k]), 128'd1);
      lat[k] = -1;
      got[k] = '0;
    end
    @(posedge clk);
    #1;
    sw_vin = 1'b0;
    for (int j = 1; j <= 40; j++) begin
      @(negedge clk);
      #2;
      for (int k = 0; k < 4; k++) begin
        if (sw_vo[k] && lat[k] < 0) begin
          lat[k] = j - 1;
          got[k] = sw_do[k];
        end
      end
    end
    for (int k = 0; k < 4; k++) begin
      chk("sweep_latency", 128'(lat[k]), 128'(16 / SW_L[k]));
      chk("sweep_data", got[k], 128'h0f0e0d0c0b0a09080706050403020100);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
